// File: rtl/dlyb_cal_pkg.sv
// Shared types and helpers for the dlyb delay-chain calibration controller.
package dlyb_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DECIDE,
        ST_TRACK_WAIT
    } state_t;

    typedef enum logic {
        MODE_SEARCH,
        MODE_TRACK
    } mode_t;

    typedef enum logic [1:0] {
        VP_IDLE,
        VP_SETTLE,
        VP_SAMPLE,
        VP_HOLD
    } vphase_t;

    // Majority threshold: vote is 1 when the count of ones exceeds this.
    function automatic int unsigned vote_thresh(input int unsigned nsamp);
        return nsamp / 2;
    endfunction

endpackage

// File: rtl/dlyb_cal_vote.sv
// Settle wait, phase-detector sampling and majority vote for one tap evaluation.
module dlyb_cal_vote
    import dlyb_cal_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned NSAMP      = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic start,
    input  logic pd,
    output logic settle_done,
    output logic sample_done,
    output logic decide_valid,
    output logic vote
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned VW = $clog2(NSAMP + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [VW-1:0] SAMP_LAST   = VW'(NSAMP - 1);
    localparam logic [VW-1:0] THRESH      = VW'(vote_thresh(NSAMP));

    vphase_t       phase_q, phase_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [VW-1:0] samp_cnt_q, samp_cnt_d;
    logic [VW-1:0] ones_q, ones_d;

    assign settle_done  = (phase_q == VP_SETTLE) && (settle_cnt_q == SETTLE_LAST);
    assign sample_done  = (phase_q == VP_SAMPLE) && (samp_cnt_q == SAMP_LAST);
    assign decide_valid = (phase_q == VP_HOLD);
    assign vote         = ones_q > THRESH;

    always_comb begin
        phase_d      = phase_q;
        settle_cnt_d = settle_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        ones_d       = ones_q;
        if (clear) begin
            phase_d      = VP_IDLE;
            settle_cnt_d = '0;
            samp_cnt_d   = '0;
            ones_d       = '0;
        end else if (start) begin
            phase_d      = VP_SETTLE;
            settle_cnt_d = '0;
            samp_cnt_d   = '0;
            ones_d       = '0;
        end else begin
            case (phase_q)
                VP_SETTLE: begin
                    if (settle_done) phase_d = VP_SAMPLE;
                    else             settle_cnt_d = settle_cnt_q + SW'(1);
                end
                VP_SAMPLE: begin
                    ones_d = ones_q + VW'(pd);
                    if (sample_done) phase_d = VP_HOLD;
                    else             samp_cnt_d = samp_cnt_q + VW'(1);
                end
                VP_HOLD:  phase_d = VP_IDLE;
                default:  phase_d = VP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= VP_IDLE;
            settle_cnt_q <= '0;
            samp_cnt_q   <= '0;
            ones_q       <= '0;
        end else begin
            phase_q      <= phase_d;
            settle_cnt_q <= settle_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            ones_q       <= ones_d;
        end
    end

endmodule

// File: rtl/dlyb_chain_cal_ctrl.sv
// Delay-line tap calibration: linear search for the first "late" tap, then
// periodic +/-1 bang-bang tracking of that tap; sole source of tap select.
module dlyb_chain_cal_ctrl
    import dlyb_cal_pkg::*;
#(
    parameter int unsigned NTAP       = 16,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned NSAMP      = 5,
    parameter int unsigned TRACK_INT  = 256,
    localparam int unsigned TAPW      = $clog2(NTAP)
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            START,
    input  logic            PD,
    input  logic            OVR_EN,
    input  logic [TAPW-1:0] OVR_TAP,
    output logic [TAPW-1:0] TAP,
    output logic            BUSY,
    output logic            DONE,
    output logic            LOCKED,
    output logic            ERR
);

    localparam int unsigned     TW       = $clog2(TRACK_INT + 1);
    localparam logic [TAPW-1:0] TAP_MAX  = TAPW'(NTAP - 1);
    localparam logic [TW-1:0]   TRK_LAST = TW'(TRACK_INT - 1);

    state_t          state_q, state_d;
    mode_t           mode_q, mode_d;
    logic [TAPW-1:0] tap_q, tap_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            locked_q, locked_d;
    logic            err_q, err_d;
    logic [TW-1:0]   trk_cnt_q, trk_cnt_d;

    logic vote_clear, vote_start;
    logic settle_done, sample_done, decide_valid, vote;

    dlyb_cal_vote #(
        .SETTLE_CYC(SETTLE_CYC),
        .NSAMP     (NSAMP)
    ) u_vote (
        .clk         (CLK),
        .rst_n       (RN),
        .clear       (vote_clear),
        .start       (vote_start),
        .pd          (PD),
        .settle_done (settle_done),
        .sample_done (sample_done),
        .decide_valid(decide_valid),
        .vote        (vote)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tap_d      = tap_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        locked_d   = locked_q;
        err_d      = err_q;
        trk_cnt_d  = '0;
        vote_clear = 1'b0;
        vote_start = 1'b0;
        if (OVR_EN) begin
            // Clamp keeps TAP legal when NTAP is not a power of two.
            state_d    = ST_IDLE;
            mode_d     = MODE_SEARCH;
            tap_d      = (OVR_TAP > TAP_MAX) ? TAP_MAX : OVR_TAP;
            locked_d   = 1'b0;
            busy_d     = 1'b0;
            vote_clear = 1'b1;
        end else if (START && (state_q == ST_IDLE || state_q == ST_TRACK_WAIT)) begin
            state_d    = ST_SETTLE;
            mode_d     = MODE_SEARCH;
            tap_d      = '0;
            busy_d     = 1'b1;
            err_d      = 1'b0;
            locked_d   = 1'b0;
            vote_start = 1'b1;
        end else begin
            case (state_q)
                ST_SETTLE: if (settle_done) state_d = ST_SAMPLE;
                ST_SAMPLE: if (sample_done) state_d = ST_DECIDE;
                ST_DECIDE: begin
                    if (decide_valid) begin
                        if (mode_q == MODE_SEARCH) begin
                            if (vote) begin
                                locked_d = 1'b1;
                                busy_d   = 1'b0;
                                done_d   = 1'b1;
                                state_d  = ST_TRACK_WAIT;
                            end else if (tap_q != TAP_MAX) begin
                                tap_d      = tap_q + TAPW'(1);
                                state_d    = ST_SETTLE;
                                vote_start = 1'b1;
                            end else begin
                                err_d   = 1'b1;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            if (vote) begin
                                if (tap_q != '0) tap_d = tap_q - TAPW'(1);
                                state_d = ST_TRACK_WAIT;
                            end else if (tap_q != TAP_MAX) begin
                                tap_d   = tap_q + TAPW'(1);
                                state_d = ST_TRACK_WAIT;
                            end else begin
                                err_d    = 1'b1;
                                locked_d = 1'b0;
                                state_d  = ST_IDLE;
                            end
                        end
                    end
                end
                ST_TRACK_WAIT: begin
                    if (trk_cnt_q == TRK_LAST) begin
                        mode_d     = MODE_TRACK;
                        state_d    = ST_SETTLE;
                        vote_start = 1'b1;
                    end else begin
                        trk_cnt_d = trk_cnt_q + TW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_SEARCH;
            tap_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            trk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            tap_q     <= tap_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            trk_cnt_q <= trk_cnt_d;
        end
    end

    assign TAP    = tap_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign LOCKED = locked_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_dlyb_chain_cal_ctrl.sv
// Bench for dlyb_chain_cal_ctrl: directed scenarios plus random stimulus, with a
// cycle-offset reference model compared against the outputs every cycle.
module tb_dlyb_chain_cal_ctrl;

    localparam int NT = 16;
    localparam int S  = 8;
    localparam int N  = 5;
    localparam int TI = 256;

    localparam int A_IDLE = 0;
    localparam int A_EVAL = 1;
    localparam int A_WAIT = 2;

    logic       clk = 1'b0;
    logic       rn = 1'b0;
    logic       start = 1'b0;
    logic       pd = 1'b0;
    logic       ovr_en = 1'b0;
    logic [3:0] ovr_tap = '0;
    logic [3:0] tap;
    logic       busy, done, locked, err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_tap = 0, m_act = A_IDLE, m_t = 0, m_ones = 0;
    bit m_search = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_locked = 1'b0, m_err = 1'b0;

    // PD source: 0 = (tap>=thr), 1 = const 0, 2 = const 1, 3 = per-tap pattern, 4 = random
    int         pd_mode = 1;
    int         thr = 0;
    logic [4:0] pat [2];

    always #5 clk = ~clk;

    dlyb_chain_cal_ctrl dut (
        .CLK    (clk),
        .RN     (rn),
        .START  (start),
        .PD     (pd),
        .OVR_EN (ovr_en),
        .OVR_TAP(ovr_tap),
        .TAP    (tap),
        .BUSY   (busy),
        .DONE   (done),
        .LOCKED (locked),
        .ERR    (err)
    );

    task automatic model_step();
        bit v;
        m_done = 1'b0;
        if (!rn) begin
            m_tap = 0; m_busy = 0; m_locked = 0; m_err = 0;
            m_act = A_IDLE; m_t = 0; m_ones = 0; m_search = 1;
        end else if (ovr_en) begin
            m_act = A_IDLE; m_t = 0; m_ones = 0;
            m_tap = (int'(ovr_tap) > NT - 1) ? NT - 1 : int'(ovr_tap);
            m_locked = 0; m_busy = 0;
        end else if (start && (m_act == A_IDLE || m_act == A_WAIT)) begin
            m_tap = 0; m_busy = 1; m_err = 0; m_locked = 0;
            m_search = 1; m_act = A_EVAL; m_t = 0; m_ones = 0;
        end else if (m_act == A_EVAL) begin
            m_t++;
            if (m_t > S && m_t <= S + N) m_ones += int'(pd);
            if (m_t == S + N + 1) begin
                v = (2 * m_ones > N);
                m_t = 0;
                m_ones = 0;
                if (m_search) begin
                    if (v) begin
                        m_locked = 1; m_busy = 0; m_done = 1; m_act = A_WAIT;
                    end else if (m_tap < NT - 1) begin
                        m_tap++;
                    end else begin
                        m_err = 1; m_busy = 0; m_done = 1; m_act = A_IDLE;
                    end
                end else begin
                    if (v) begin
                        if (m_tap > 0) m_tap--;
                        m_act = A_WAIT;
                    end else if (m_tap < NT - 1) begin
                        m_tap++;
                        m_act = A_WAIT;
                    end else begin
                        m_err = 1; m_locked = 0; m_act = A_IDLE;
                    end
                end
            end
        end else if (m_act == A_WAIT) begin
            m_t++;
            if (m_t == TI) begin
                m_act = A_EVAL; m_search = 0; m_t = 0; m_ones = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
            n_cmp++;
            if (int'(tap) != m_tap || busy !== m_busy || done !== m_done ||
                locked !== m_locked || err !== m_err) begin
                n_bad++;
                $display("FAIL outputs @%0t: TAP/BUSY/DONE/LOCKED/ERR got %0d/%b/%b/%b/%b expected %0d/%b/%b/%b/%b",
                         $time, tap, busy, done, locked, err, m_tap, m_busy, m_done, m_locked, m_err);
            end
        end
    end

    function automatic logic calc_pd();
        int idx;
        case (pd_mode)
            0: return logic'(m_tap >= thr);
            1: return 1'b0;
            2: return 1'b1;
            3: begin
                idx = m_t - S;
                if (m_act == A_EVAL && idx >= 0 && idx < N && m_tap < 2) return pat[m_tap][idx];
                return 1'b0;
            end
            default: return logic'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        pd = calc_pd();
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_tap_change(input int max, output int n);
        logic [3:0] t0;
        t0 = tap;
        n = 0;
        while (tap == t0 && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, len, r;
        pat[0] = 5'b00011;   // samples 1,1,0,0,0
        pat[1] = 5'b10101;   // samples 1,0,1,0,1

        repeat (3) tick();
        chk("reset_tap", int'(tap), 0);
        chk("reset_flags", int'({busy, done, locked, err}), 0);
        rn = 1'b1;
        repeat (2) tick();

        // lock at first late tap 3: 4 taps x 14 cycles
        pd_mode = 0; thr = 3;
        pulse_start();
        wait_done(400, n);
        chk("lock3_latency", n, 56);
        chk("lock3_tap", int'(tap), 3);
        chk("lock3_locked", int'(locked), 1);
        chk("lock3_busy", int'(busy), 0);
        tick();
        chk("done_is_pulse", int'(done), 0);

        // tracking from tap 4: down then up
        thr = 4;
        pulse_start();
        wait_done(400, n);
        chk("lock4_latency", n, 70);
        chk("lock4_tap", int'(tap), 4);
        pd_mode = 2;
        wait_tap_change(600, n);
        chk("track_down_latency", n, TI + 14);
        chk("track_down_tap", int'(tap), 3);
        pd_mode = 1;
        wait_tap_change(600, n);
        chk("track_up_latency", n, TI + 14);
        chk("track_up_tap", int'(tap), 4);

        // locked at tap 0 with PD=1 holds at 0
        pd_mode = 2;
        pulse_start();
        wait_done(400, n);
        chk("lock0_latency", n, 14);
        repeat (600) tick();
        chk("track_hold0_tap", int'(tap), 0);
        chk("track_hold0_locked", int'(locked), 1);

        // PD stuck low: run off the chain
        pd_mode = 1;
        pulse_start();
        wait_done(400, n);
        chk("err_latency", n, 224);
        chk("err_flag", int'(err), 1);
        chk("err_tap", int'(tap), 15);
        chk("err_locked", int'(locked), 0);
        repeat (50) tick();
        chk("err_sticky", int'(err), 1);
        pd_mode = 0; thr = 2;
        pulse_start();
        chk("err_cleared", int'(err), 0);
        chk("restart_busy", int'(busy), 1);
        wait_done(400, n);
        chk("lock2_tap", int'(tap), 2);

        // majority filter
        pd_mode = 3;
        pulse_start();
        wait_done(400, n);
        chk("majority_latency", n, 28);
        chk("majority_tap", int'(tap), 1);
        chk("majority_locked", int'(locked), 1);

        // override during SAMPLE with START held
        pd_mode = 1;
        pulse_start();
        repeat (10) tick();
        ovr_en = 1'b1; ovr_tap = 4'd9; start = 1'b1;
        tick();
        chk("ovr_tap", int'(tap), 9);
        chk("ovr_flags", int'({busy, done, locked}), 0);
        repeat (20) tick();
        chk("ovr_hold_tap", int'(tap), 9);
        ovr_en = 1'b0;
        tick();
        start = 1'b0;
        chk("ovr_restart_tap", int'(tap), 0);
        chk("ovr_restart_busy", int'(busy), 1);

        // asynchronous reset mid-search
        n = 0;
        while (tap != 4'd5 && n < 200) begin
            tick();
            n++;
        end
        chk("reach_tap5", int'(tap), 5);
        repeat (3) tick();
        #2 rn = 1'b0;
        #1;
        chk("async_rst_tap", int'(tap), 0);
        chk("async_rst_flags", int'({busy, done, locked, err}), 0);
        repeat (2) tick();
        rn = 1'b1;
        tick();

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            pd_mode = $urandom_range(0, 4);
            thr = $urandom_range(0, 15);
            r = $urandom_range(0, 9);
            if (r < 6) begin
                pulse_start();
            end else if (r < 8) begin
                ovr_en = 1'b1;
                ovr_tap = 4'($urandom);
                tick();
                ovr_en = 1'b0;
            end
            len = $urandom_range(10, 600);
            for (int c = 0; c < len; c++) begin
                start = ($urandom_range(0, 199) == 0);
                tick();
            end
            start = 1'b0;
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
